fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 8-bit CPU, directly upstream of the CPU control sequencer. It owns the program counter, drives the instruction-RAM read port, latches the fetched byte into the instruction register, and supplies `opcode` back to the sequencer. Every action is keyed off the sequencer's 4-bit `state` code and its `allow_up` flag.

## Interface
Parameters:
- `ADDR_W`, 8, program counter and RAM address width.
- `RESET_PC`, 0, PC value after reset.
- `JUMP_OP`, 4'hF, opcode that selects the jump path.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `state` in 4: sequencer state code (encoding below).
- `allow_up` in 1: PC increment permit from the sequencer.
- `mem_rdata` in 8: instruction RAM read data; synchronous RAM with 1-cycle read latency.
- `mem_addr` out ADDR_W: RAM read address (combinational).
- `mem_rd` out 1: RAM read strobe (combinational).
- `pc` out ADDR_W: current program counter (registered).
- `ir` out 8: instruction register (registered).
- `opcode` out 4: `ir[7:4]`.
- `operand` out 4: `ir[3:0]`.
- `jump_taken` out 1: one-cycle pulse (registered) when the PC is loaded by a jump.

## Operation
State codes: IDLE=0, PC=1, RAM=2, IR=3, BUFFER=4, REG_IN=5, ALU=6, ALU_OUT=7, REG_OUT=8, ROM=9, JUMP=10.

- **PC (1):**
  - `mem_rd`=1, `mem_addr`=`pc`.
- **RAM (2):**
  - Latch `mem_rdata` into the internal fetch buffer `fbuf`.
- **IR (3):**
  - `ir` <= `fbuf`.
- **BUFFER (4):**
  - No register update. `opcode` is stable and valid here for the sequencer's branch decision.
- **JUMP (10):**
  - `mem_rd`=1, `mem_addr`= jump target = `operand` zero-extended to ADDR_W.
  - `pc` <= target.
  - `jump_taken` <= 1 for one cycle.
  - The sequencer then goes straight to RAM, so the read must issue in this cycle.
- **ROM (9):**
  - If `allow_up`=1, `pc` <= `pc`+1, modulo 2^ADDR_W (0xFF -> 0x00 wraps silently).
  - If `allow_up`=0, `pc` holds.
- **All other codes (0, 5-8, 11-15):**
  - `mem_rd`=0, `mem_addr`=`pc`.
  - All registers hold. Codes 11-15 produce no error and no side effect.
- **Reset:**
  - `pc`=RESET_PC, `fbuf`=0, `ir`=0 (so `opcode`=0, `operand`=0), `jump_taken`=0.
  - Combinational outputs follow from `state`.
  - Reset mid-fetch discards `fbuf` and any pending jump; `rst` has priority over every state action.

## Timing
- Each fetch takes 3 cycles to reach `ir`:
  - cycle t, PC: address issued;
  - t+1, RAM: `mem_rdata` valid, captured;
  - t+2, IR: `ir` loaded at the end of the cycle;
  - t+3, BUFFER: `opcode` valid.
- Jump path:
  - JUMP at cycle j: target address issued, `pc` = target from j+1.
  - RAM at j+1 captures the target instruction.
  - `ir` updated at the end of j+2.
- `jump_taken` is high exactly during cycle j+1.
- PC increment takes effect the cycle after ROM, i.e. on entry to the next PC state.
- `allow_up` is sampled only in ROM. It is ignored in every other state.

## Configuration
- `FETCH_ICOUNT_EN`: adds output `icount` (16 bits) and its counter.
  - Reset to 0.
  - Incremented at the end of every IR-state cycle.
  - Saturates at 0xFFFF.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package `cpu8_pkg`:
  - the state code localparams (0-10), shared with the sequencer;
  - `JUMP_OP` default;
  - instruction field positions (opcode [7:4], operand [3:0]).
- Sub-module `pc_counter`: ADDR_W register with synchronous reset to RESET_PC, load-enable plus load value, increment-enable, wrap-around. Load has priority over increment.
- The fetch buffer, IR, jump pulse and address mux stay in `fetch_unit`.

## Test plan
- **Reset then straight fetch:** `rst` for 2 cycles, RAM[0]=0x35, drive states 1,2,3,4 -> `mem_rd`=1 with `mem_addr`=0 in state 1; `opcode`=3 and `operand`=5 in state 4; `pc`=0.
- **Increment:** full non-jump sequence 1-9 with `allow_up`=1 in ROM -> `pc`=1 on the next state 1. Repeat with `allow_up`=0 in ROM -> `pc` stays 0.
- **Jump:**
  - Setup: `ir`=0xF7, state 10, RAM[7]=0x12.
  - `mem_addr`=7 and `mem_rd`=1 during JUMP.
  - `pc`=7 and `jump_taken`=1 the next cycle.
  - After RAM and IR, `ir`=0x12.
- **Wrap:** `pc`=0xFF, ROM with `allow_up`=1 -> `pc`=0x00.
- **Reset mid-operation:** `rst` asserted during state 2 with `mem_rdata`=0xAA -> `ir` stays 0x00, `pc`=RESET_PC, no `jump_taken`.
- **Illegal codes and icount:** states 11-15 -> no register changes, `mem_rd`=0. With `FETCH_ICOUNT_EN`, `icount` counts 3 after three IR cycles.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: sequencer state codes, default jump opcode
// and instruction field positions.
package cpu8_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PC      = 4'd1,
    ST_RAM     = 4'd2,
    ST_IR      = 4'd3,
    ST_BUFFER  = 4'd4,
    ST_REG_IN  = 4'd5,
    ST_ALU     = 4'd6,
    ST_ALU_OUT = 4'd7,
    ST_REG_OUT = 4'd8,
    ST_ROM     = 4'd9,
    ST_JUMP    = 4'd10
  } state_e;

  localparam logic [3:0] JUMP_OP_DEF = 4'hF;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned OPR_MSB = 3;
  localparam int unsigned OPR_LSB = 0;

  localparam int unsigned ICOUNT_W = 16;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: synchronous reset to RESET_PC, load (priority) or increment,
// silent wrap-around at 2^ADDR_W.
module pc_counter #(
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld_i) begin
      pc_d = ld_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, RAM read port, fetch buffer, IR and jump pulse.
// Optional FETCH_ICOUNT_EN adds a saturating 16-bit count of IR loads on icount.
module fetch_unit
  import cpu8_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        JUMP_OP  = JUMP_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        state,
  input  logic              allow_up,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              jump_taken
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [ICOUNT_W-1:0] icount
`endif
);

  // JUMP_OP is decoded by the sequencer; it lives here so both share one override.
  if (ADDR_W < 4) begin : g_chk_addr_w
    $error("ADDR_W must be wide enough for a 4-bit jump target");
  end
  if (JUMP_OP == 4'h0) begin : g_chk_jump_op
    $error("JUMP_OP of 0 would alias the post-reset opcode");
  end

  logic [7:0]        fbuf_q, fbuf_d;
  logic [7:0]        ir_q, ir_d;
  logic              jump_q, jump_d;
  logic              pc_ld, pc_inc;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] target;

  assign target = ADDR_W'(ir_q[OPR_MSB:OPR_LSB]);

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    fbuf_d   = fbuf_q;
    ir_d     = ir_q;
    jump_d   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    case (state)
      ST_PC:   mem_rd = 1'b1;
      ST_RAM:  fbuf_d = mem_rdata;
      ST_IR:   ir_d = fbuf_q;
      ST_ROM:  pc_inc = allow_up;
      // Read issues now because the sequencer goes straight to RAM next.
      ST_JUMP: begin
        mem_rd   = 1'b1;
        mem_addr = target;
        pc_ld    = 1'b1;
        jump_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_q <= '0;
      ir_q   <= '0;
      jump_q <= 1'b0;
    end else begin
      fbuf_q <= fbuf_d;
      ir_q   <= ir_d;
      jump_q <= jump_d;
    end
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (pc_ld),
    .ld_val_i (target),
    .inc_i    (pc_inc),
    .pc_o     (pc_q)
  );

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_MSB:OPC_LSB];
  assign operand    = ir_q[OPR_MSB:OPR_LSB];
  assign jump_taken = jump_q;

`ifdef FETCH_ICOUNT_EN
  logic [ICOUNT_W-1:0] icount_q, icount_d;

  always_comb begin
    icount_d = icount_q;
    if ((state == ST_IR) && (icount_q != '1)) begin
      icount_d = icount_q + ICOUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences and randomized states checked against a behavioural model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] state = 4'd0;
  logic       allow_up = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       jump_taken;
`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [256];

  // Behavioural model state
  logic [7:0] m_pc, m_fbuf, m_ir, m_rdata;
  logic       m_jt;
  int         m_icount;

  typedef struct {
    logic       r;
    logic [3:0] st;
    logic       au;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       jt;
    logic       rd;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl[26];

  fetch_unit #(
    .ADDR_W   (8),
    .RESET_PC (8'h00),
    .JUMP_OP  (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .allow_up   (allow_up),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .operand    (operand),
    .jump_taken (jump_taken)
`ifdef FETCH_ICOUNT_EN
    ,
    .icount     (icount)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  function automatic vec_t mk(logic r, logic [3:0] st, logic au, logic [7:0] p,
                              logic [7:0] i, logic jt, logic rd, logic [7:0] a);
    vec_t v;
    v.r = r; v.st = st; v.au = au; v.pc = p; v.ir = i; v.jt = jt; v.rd = rd; v.addr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] st, input logic au);
    @(negedge clk);
    rst = r;
    state = st;
    allow_up = au;
    #1;
  endtask

  function automatic logic exp_rd(input logic [3:0] st);
    return (st == 4'd1) || (st == 4'd10);
  endfunction

  function automatic logic [7:0] exp_addr(input logic [3:0] st);
    return (st == 4'd10) ? {4'h0, m_ir[3:0]} : m_pc;
  endfunction

  task automatic model_check(input logic [3:0] st);
    chk("pc", 16'(pc), 16'(m_pc));
    chk("ir", 16'(ir), 16'(m_ir));
    chk("opcode", 16'(opcode), 16'(m_ir >> 4));
    chk("operand", 16'(operand), 16'(m_ir & 8'h0F));
    chk("jump_taken", 16'(jump_taken), 16'(m_jt));
    chk("mem_rd", 16'(mem_rd), 16'(exp_rd(st)));
    chk("mem_addr", 16'(mem_addr), 16'(exp_addr(st)));
`ifdef FETCH_ICOUNT_EN
    chk("icount", icount, 16'(m_icount));
`endif
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_step(input logic r, input logic [3:0] st, input logic au);
    logic       rd;
    logic [7:0] a, nxt_rdata;
    rd = exp_rd(st);
    a  = exp_addr(st);
    nxt_rdata = rd ? ram[a] : m_rdata;
    if (r) begin
      m_pc = 8'h00; m_fbuf = 8'h00; m_ir = 8'h00; m_jt = 1'b0; m_icount = 0;
    end else begin
      m_jt = (st == 4'd10);
      case (st)
        4'd2:  m_fbuf = m_rdata;
        4'd3:  begin
          m_ir = m_fbuf;
          if (m_icount < 65535) m_icount++;
        end
        4'd9:  if (au) m_pc = 8'((int'(m_pc) + 1) % 256);
        4'd10: m_pc = a;
        default: ;
      endcase
    end
    m_rdata = nxt_rdata;
  endtask

  task automatic cyc(input logic r, input logic [3:0] st, input logic au);
    apply(r, st, au);
    model_check(st);
    model_step(r, st, au);
  endtask

  initial begin
    m_pc = 8'h00; m_fbuf = 8'h00; m_ir = 8'h00; m_jt = 1'b0; m_rdata = 8'h00; m_icount = 0;
    foreach (ram[i]) ram[i] = 8'h00;
    ram[0] = 8'h35;
    ram[1] = 8'hF7;
    ram[3] = 8'hAA;
    ram[7] = 8'h12;

    //             r  st    au  pc     ir     jt rd addr
    tbl[0]  = mk(1, 4'd0,  0, 8'h00, 8'h00, 0, 0, 8'h00);
    tbl[1]  = mk(0, 4'd1,  0, 8'h00, 8'h00, 0, 1, 8'h00);
    tbl[2]  = mk(0, 4'd2,  0, 8'h00, 8'h00, 0, 0, 8'h00);
    tbl[3]  = mk(0, 4'd3,  0, 8'h00, 8'h00, 0, 0, 8'h00);
    tbl[4]  = mk(0, 4'd4,  0, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[5]  = mk(0, 4'd5,  1, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[6]  = mk(0, 4'd6,  1, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[7]  = mk(0, 4'd7,  1, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[8]  = mk(0, 4'd8,  1, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[9]  = mk(0, 4'd9,  1, 8'h00, 8'h35, 0, 0, 8'h00);
    tbl[10] = mk(0, 4'd1,  0, 8'h01, 8'h35, 0, 1, 8'h01);
    tbl[11] = mk(0, 4'd2,  0, 8'h01, 8'h35, 0, 0, 8'h01);
    tbl[12] = mk(0, 4'd3,  0, 8'h01, 8'h35, 0, 0, 8'h01);
    tbl[13] = mk(0, 4'd4,  0, 8'h01, 8'hF7, 0, 0, 8'h01);
    tbl[14] = mk(0, 4'd10, 0, 8'h01, 8'hF7, 0, 1, 8'h07);
    tbl[15] = mk(0, 4'd2,  0, 8'h07, 8'hF7, 1, 0, 8'h07);
    tbl[16] = mk(0, 4'd3,  0, 8'h07, 8'hF7, 0, 0, 8'h07);
    tbl[17] = mk(0, 4'd4,  0, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[18] = mk(0, 4'd9,  0, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[19] = mk(0, 4'd1,  1, 8'h07, 8'h12, 0, 1, 8'h07);
    tbl[20] = mk(0, 4'd11, 1, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[21] = mk(0, 4'd12, 1, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[22] = mk(0, 4'd13, 1, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[23] = mk(0, 4'd14, 1, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[24] = mk(0, 4'd15, 1, 8'h07, 8'h12, 0, 0, 8'h07);
    tbl[25] = mk(0, 4'd0,  0, 8'h07, 8'h12, 0, 0, 8'h07);

    // Two reset cycles before anything is observable
    apply(1'b1, 4'd0, 1'b0); model_step(1'b1, 4'd0, 1'b0);
    apply(1'b1, 4'd0, 1'b0); model_step(1'b1, 4'd0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i].r, tbl[i].st, tbl[i].au);
      chk($sformatf("tbl%0d_pc", i), 16'(pc), 16'(tbl[i].pc));
      chk($sformatf("tbl%0d_ir", i), 16'(ir), 16'(tbl[i].ir));
      chk($sformatf("tbl%0d_opcode", i), 16'(opcode), 16'(tbl[i].ir >> 4));
      chk($sformatf("tbl%0d_operand", i), 16'(operand), 16'(tbl[i].ir & 8'h0F));
      chk($sformatf("tbl%0d_jt", i), 16'(jump_taken), 16'(tbl[i].jt));
      chk($sformatf("tbl%0d_rd", i), 16'(mem_rd), 16'(tbl[i].rd));
      chk($sformatf("tbl%0d_addr", i), 16'(mem_addr), 16'(tbl[i].addr));
      model_step(tbl[i].r, tbl[i].st, tbl[i].au);
    end

    // Reset during JUMP: pending load and pulse are discarded
    cyc(1'b1, 4'd10, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    chk("jmp_rst_pc", 16'(pc), 16'h0000);
    chk("jmp_rst_jt", 16'(jump_taken), 16'h0000);

    // Reset during RAM while mem_rdata carries 0xAA
    cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b0, 4'd1, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    chk("mid_rst_rdata_seen", 16'(mem_rdata), 16'h00AA);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd4, 1'b0);
    chk("mid_rst_ir", 16'(ir), 16'h0000);
    chk("mid_rst_pc", 16'(pc), 16'h0000);
    chk("mid_rst_jt", 16'(jump_taken), 16'h0000);

    // Wrap from 0xFF to 0x00
    cyc(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 255; i++) cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b0, 4'd0, 1'b0);
    chk("wrap_pc_ff", 16'(pc), 16'h00FF);
    cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b0, 4'd0, 1'b0);
    chk("wrap_pc_00", 16'(pc), 16'h0000);

`ifdef FETCH_ICOUNT_EN
    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    chk("icount_3", icount, 16'd3);
`endif

    // Randomized states against the model
    foreach (ram[i]) ram[i] = 8'($urandom);
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic [3:0] st;
      logic       au;
      r  = ($urandom_range(0, 39) == 0);
      st = 4'($urandom_range(0, 15));
      au = 1'($urandom);
      cyc(r, st, au);
    end
    apply(1'b0, 4'd0, 1'b0);
    model_check(4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
